// File: rtl/an29_encode_loader.sv
// an29_encode_loader: encodes data words as A*data codewords and packs them into a
// 16-lane bank that is held for a downstream decoder until acknowledged.
module an29_encode_loader #(
    parameter int A     = 29,
    parameter int DW    = 10,
    parameter int CW    = 14,
    parameter int LANES = 16,
    parameter int DMAX  = 564
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    output logic [CW-1:0] OUT0,
    output logic [CW-1:0] OUT1,
    output logic [CW-1:0] OUT2,
    output logic [CW-1:0] OUT3,
    output logic [CW-1:0] OUT4,
    output logic [CW-1:0] OUT5,
    output logic [CW-1:0] OUT6,
    output logic [CW-1:0] OUT7,
    output logic [CW-1:0] OUT8,
    output logic [CW-1:0] OUT9,
    output logic [CW-1:0] OUT10,
    output logic [CW-1:0] OUT11,
    output logic [CW-1:0] OUT12,
    output logic [CW-1:0] OUT13,
    output logic [CW-1:0] OUT14,
    output logic [CW-1:0] OUT15,
    output logic          bank_valid,
    input  logic          bank_ack,
    output logic [4:0]    fill_cnt,
    output logic          range_err,
    output logic [7:0]    err_cnt
);
    typedef enum logic {FILL, FULL} state_t;
    state_t state, state_n;
    logic [CW-1:0] lanes [LANES];
    logic [CW-1:0] d, cw;
    logic accept, ok, bad, go_full;

    assign d = CW'(in_data);
    // x29 as shifts and subtracts; any other multiplier falls back to a constant multiply
    assign cw = (A == 29) ? (d << 5) - (d << 1) - d : CW'(A) * d;
    assign accept = in_valid && in_ready;
    assign ok = accept && (32'(in_data) <= DMAX);
    assign bad = accept && (32'(in_data) > DMAX);
    assign in_ready = (state == FILL);
    assign bank_valid = (state == FULL);

    always_comb begin
        go_full = (ok && fill_cnt == 5'(LANES - 1)) || (flush && (fill_cnt != 5'd0 || ok));
        state_n = (state == FILL) ? (go_full ? FULL : FILL) : (bank_ack ? FILL : FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes <= '{default: '0};
            fill_cnt <= 5'd0;
            range_err <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            range_err <= bad;
            if (bad && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
            if (state == FULL && bank_ack) begin
                lanes <= '{default: '0};
                fill_cnt <= 5'd0;
            end else if (ok) begin
                lanes[fill_cnt[3:0]] <= cw;
                fill_cnt <= fill_cnt + 5'd1;
            end
        end
    end

    assign OUT0  = lanes[0];
    assign OUT1  = lanes[1];
    assign OUT2  = lanes[2];
    assign OUT3  = lanes[3];
    assign OUT4  = lanes[4];
    assign OUT5  = lanes[5];
    assign OUT6  = lanes[6];
    assign OUT7  = lanes[7];
    assign OUT8  = lanes[8];
    assign OUT9  = lanes[9];
    assign OUT10 = lanes[10];
    assign OUT11 = lanes[11];
    assign OUT12 = lanes[12];
    assign OUT13 = lanes[13];
    assign OUT14 = lanes[14];
    assign OUT15 = lanes[15];
endmodule

// File: tb/tb_an29_encode_loader.sv
// tb_an29_encode_loader: directed and random stimulus against a bank-level model
// that tracks codewords as A*data in an array.
module tb_an29_encode_loader;
    localparam int A = 29;
    localparam int DMAX = 564;

    logic clk = 0, rst = 1, in_valid = 0, flush = 0, bank_ack = 0;
    logic [9:0] in_data = '0;
    logic in_ready, bank_valid, range_err;
    logic [4:0] fill_cnt;
    logic [7:0] err_cnt;
    logic [13:0] outs [16];

    int total = 0, bad = 0;
    int m_lane [16];
    int m_cnt = 0, m_ecnt = 0;
    bit m_full = 0, m_rerr = 0;

    always #5 clk = ~clk;

    an29_encode_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush),
        .OUT0(outs[0]), .OUT1(outs[1]), .OUT2(outs[2]), .OUT3(outs[3]),
        .OUT4(outs[4]), .OUT5(outs[5]), .OUT6(outs[6]), .OUT7(outs[7]),
        .OUT8(outs[8]), .OUT9(outs[9]), .OUT10(outs[10]), .OUT11(outs[11]),
        .OUT12(outs[12]), .OUT13(outs[13]), .OUT14(outs[14]), .OUT15(outs[15]),
        .bank_valid(bank_valid), .bank_ack(bank_ack), .fill_cnt(fill_cnt),
        .range_err(range_err), .err_cnt(err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        total++;
        if (got !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".fill_cnt"}, 32'(fill_cnt), m_cnt);
        chk({tag, ".bank_valid"}, 32'(bank_valid), int'(m_full));
        chk({tag, ".in_ready"}, 32'(in_ready), int'(!m_full));
        chk({tag, ".range_err"}, 32'(range_err), int'(m_rerr));
        chk({tag, ".err_cnt"}, 32'(err_cnt), m_ecnt);
        for (int i = 0; i < 16; i++) chk($sformatf("%s.OUT%0d", tag, i), 32'(outs[i]), m_lane[i]);
    endtask

    task automatic model_reset();
        m_lane = '{default: 0};
        m_cnt = 0;
        m_ecnt = 0;
        m_full = 0;
        m_rerr = 0;
    endtask

    task automatic step(input string tag, input bit v, input int dat, input bit f, input bit ack);
        in_valid = v;
        in_data = 10'(dat);
        flush = f;
        bank_ack = ack;
        @(posedge clk);
        #1;
        m_rerr = 0;
        if (!m_full) begin
            if (v && dat > DMAX) begin
                m_rerr = 1;
                if (m_ecnt < 255) m_ecnt++;
            end else if (v) begin
                m_lane[m_cnt] = A * dat;
                m_cnt++;
            end
            if (m_cnt == 16 || (f && m_cnt > 0)) m_full = 1;
        end else if (ack) begin
            m_lane = '{default: 0};
            m_cnt = 0;
            m_full = 0;
        end
        in_valid = 0;
        flush = 0;
        bank_ack = 0;
        check_all(tag);
    endtask

    task automatic apply_reset(input string tag);
        rst = 1;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        check_all(tag);
        rst = 0;
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset_hold");
        @(posedge clk);
        #1;
        rst = 0;
        check_all("reset_release");

        for (int i = 1; i <= 16; i++) step("fill16", 1, i, 0, 0);
        chk("fill16.OUT15_const", 32'(outs[15]), 464);
        chk("fill16.bank_valid_const", 32'(bank_valid), 1);
        for (int i = 0; i < 3; i++) step("full_hold", 1, 5, 1, 0);
        step("ack_with_valid", 1, 5, 0, 1);
        step("after_ack_accept", 1, 5, 0, 0);
        chk("after_ack.OUT0_const", 32'(outs[0]), 145);
        apply_reset("reset_mid");

        step("dmax", 1, 564, 0, 0);
        step("dmax_plus1", 1, 565, 0, 0);
        chk("dmax.OUT0_const", 32'(outs[0]), 16356);
        step("rerr_clear", 0, 0, 0, 0);
        step("flush_partial", 0, 0, 1, 0);
        step("ack", 0, 0, 0, 1);

        step("zero", 1, 0, 0, 0);
        step("39", 1, 39, 0, 0);
        step("flush2", 0, 0, 1, 0);
        chk("flush2.OUT1_const", 32'(outs[1]), 1131);
        step("ack_in_full", 0, 0, 0, 1);
        step("ack_in_fill", 0, 0, 0, 1);
        step("flush_empty", 0, 0, 1, 0);
        step("flush_with_accept", 1, 7, 1, 0);
        step("ack2", 0, 0, 0, 1);

        for (int i = 0; i < 7; i++) step("pre_rst", 1, i + 3, 0, 0);
        apply_reset("rst_at7");
        step("flush_after_rst", 0, 0, 1, 0);

        for (int i = 0; i < 300; i++) step("sat", 1, 1023, 0, 0);
        chk("sat.err_cnt_const", 32'(err_cnt), 255);

        for (int i = 0; i < 3000; i++) begin
            int dat;
            dat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(565, 1023))
                                              : int'($urandom_range(0, DMAX));
            step("rand", 1'($urandom_range(0, 3) != 0), dat,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
